// File: rtl/cheat_code_loader.sv
// Cheat code loader: assembles big-endian 16-byte codes from a byte stream and strobes
// them into the cheat engine. Define CHEAT_LOADER_CHECKSUM_EN to require a 17th XOR checksum byte.
module cheat_code_loader #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned CLEAR_CYCLES  = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         s_valid,
  input  logic [7:0]   s_data,
  output logic         s_ready,
  output logic [128:0] code,
  output logic         codes_reset,
  output logic         busy,
  output logic [7:0]   applied_count,
  output logic [7:0]   err_count
);

`ifdef CHEAT_LOADER_CHECKSUM_EN
  localparam int unsigned CNT_W = 5;
  localparam int unsigned ASM_W = 128;
`else
  // Without a checksum the 16th byte goes straight into code, so only 15 bytes are assembled.
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ASM_W = 120;
`endif
  localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(ASM_W / 8);
  localparam logic [3:0]       STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0]       CLEAR_LAST  = 4'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    RECV,
    LOAD,
    STROBE_HI,
    STROBE_LO,
    CLEAR,
    CHECK
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [ASM_W-1:0]   r_asm;
  logic [127:0]       r_code;
  logic               r_strobe;
  logic               r_codes_reset;
  logic               r_s_ready;
  logic               r_busy;
  logic [7:0]         r_applied;
  logic [3:0]         r_timer;
`ifdef CHEAT_LOADER_CHECKSUM_EN
  logic [7:0]         r_err;
  logic [7:0]         r_xor;
  logic               r_chk_ok;
`endif

  logic w_accept;
  assign w_accept = s_valid & r_s_ready;

  // NOTE: clear must kill the strobe in the very cycle it is asserted, so it gates the
  // registered strobe combinationally instead of waiting for the next edge.
  assign code          = {r_strobe & ~clear, r_code};
  assign s_ready       = r_s_ready;
  assign busy          = r_busy;
  assign codes_reset   = r_codes_reset;
  assign applied_count = r_applied;
`ifdef CHEAT_LOADER_CHECKSUM_EN
  assign err_count     = r_err;
`else
  assign err_count     = 8'd0;
`endif

  // NOTE: every register here, the wide assembly and code registers included, takes the
  // asynchronous reset so code drops to zero the instant reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RECV;
      r_byte_cnt    <= '0;
      r_asm         <= '0;
      r_code        <= '0;
      r_strobe      <= 1'b0;
      r_codes_reset <= 1'b1;
      r_s_ready     <= 1'b0;
      r_busy        <= 1'b1;
      r_applied     <= '0;
      r_timer       <= '0;
`ifdef CHEAT_LOADER_CHECKSUM_EN
      r_err         <= '0;
      r_xor         <= '0;
      r_chk_ok      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking defaults here; each transition below overrides only what it drives.
      r_s_ready     <= 1'b0;
      r_busy        <= 1'b1;
      r_codes_reset <= 1'b0;
      r_strobe      <= 1'b0;

      if (clear) begin
        r_state       <= CLEAR;
        r_byte_cnt    <= '0;
        r_asm         <= '0;
        r_timer       <= CLEAR_LAST;
        r_codes_reset <= 1'b1;
        r_applied     <= '0;
`ifdef CHEAT_LOADER_CHECKSUM_EN
        r_err         <= '0;
        r_xor         <= '0;
`endif
      end else begin
        case (r_state)
          RECV: begin
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
            if (w_accept) begin
              if (r_byte_cnt == LAST_BYTE) begin
                r_byte_cnt <= '0;
                r_s_ready  <= 1'b0;
                r_busy     <= 1'b1;
`ifdef CHEAT_LOADER_CHECKSUM_EN
                r_chk_ok   <= (s_data == r_xor);
                r_xor      <= '0;
                r_state    <= CHECK;
`else
                r_code     <= {r_asm, s_data};
                r_state    <= LOAD;
`endif
              end else begin
                r_asm      <= {r_asm[ASM_W-9:0], s_data};
                r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef CHEAT_LOADER_CHECKSUM_EN
                r_xor      <= r_xor ^ s_data;
`endif
              end
            end
          end

`ifdef CHEAT_LOADER_CHECKSUM_EN
          CHECK: begin
            if (r_chk_ok) begin
              r_code  <= r_asm;
              r_state <= LOAD;
            end else begin
              r_err     <= (r_err != 8'hFF) ? r_err + 8'd1 : r_err;
              r_state   <= RECV;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b0;
            end
          end
`endif

          LOAD: begin
            r_state   <= STROBE_HI;
            r_timer   <= STROBE_LAST;
            r_strobe  <= 1'b1;
            r_applied <= (r_applied != 8'hFF) ? r_applied + 8'd1 : r_applied;
          end

          STROBE_HI: begin
            if (r_timer == 4'd0) begin
              r_state <= STROBE_LO;
              r_timer <= STROBE_LAST;
            end else begin
              r_timer  <= r_timer - 4'd1;
              r_strobe <= 1'b1;
            end
          end

          STROBE_LO: begin
            if (r_timer == 4'd0) begin
              r_state   <= RECV;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_timer <= r_timer - 4'd1;
            end
          end

          CLEAR: begin
            if (r_timer == 4'd0) begin
              r_state   <= RECV;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_timer       <= r_timer - 4'd1;
              r_codes_reset <= 1'b1;
            end
          end

          default: r_state <= RECV;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cheat_code_loader.sv
// Self-checking bench for cheat_code_loader: a cycle-stamped timeline model checked every
// cycle, plus directed literal checks. Honours CHEAT_LOADER_CHECKSUM_EN when defined.
module tb_cheat_code_loader;

`ifdef CHEAT_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int S     = 2;
  localparam int C     = 2;
  localparam int BYTES = CSUM ? 17 : 16;
  localparam int LAT   = CSUM ? 2 : 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic         s_valid = 1'b0;
  logic [7:0]   s_data = 8'h00;
  logic         s_ready;
  logic [128:0] code;
  logic         codes_reset;
  logic         busy;
  logic [7:0]   applied_count;
  logic [7:0]   err_count;

  cheat_code_loader #(.STROBE_CYCLES(S), .CLEAR_CYCLES(C)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .code          (code),
    .codes_reset   (codes_reset),
    .busy          (busy),
    .applied_count (applied_count),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Timeline model: every future effect is stamped with the cycle it becomes visible.
  bit           chk_en = 1'b0;
  logic [7:0]   m_q[$];
  logic [127:0] m_code, m_pend_code;
  int m_code_cyc, m_hi_start, m_hi_end, m_err_cyc, m_zero_cyc;
  int m_clr_start, m_clr_end, m_ready_from, m_applied, m_err;

  task automatic model_init(input int k);
    m_q.delete();
    m_code       = '0;
    m_pend_code  = '0;
    m_code_cyc   = -1;
    m_hi_start   = -1;
    m_hi_end     = -1;
    m_err_cyc    = -1;
    m_zero_cyc   = -1;
    m_applied    = 0;
    m_err        = 0;
    m_clr_start  = k;
    m_clr_end    = k;
    m_ready_from = k + 1;
  endtask

  logic         e_ready, e_strobe, e_cr;
  logic [127:0] e_word;
  logic [7:0]   e_xor;

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == m_zero_cyc) begin m_applied = 0; m_err = 0; end
      if (cyc == m_code_cyc) m_code = m_pend_code;
      if (cyc == m_hi_start) m_applied = (m_applied < 255) ? m_applied + 1 : 255;
      if (cyc == m_err_cyc)  m_err = (m_err < 255) ? m_err + 1 : 255;
      e_ready  = (cyc >= m_ready_from);
      e_strobe = (m_hi_start >= 0) && (cyc >= m_hi_start) && (cyc <= m_hi_end) && !clear;
      e_cr     = (cyc >= m_clr_start) && (cyc <= m_clr_end);
      check("code", code, {e_strobe, m_code});
      check("s_ready", 129'(s_ready), 129'(e_ready));
      check("busy", 129'(busy), 129'(!e_ready));
      check("codes_reset", 129'(codes_reset), 129'(e_cr));
      check("applied_count", 129'(applied_count), 129'(m_applied));
      check("err_count", 129'(err_count), 129'(m_err));

      if (clear) begin
        m_q.delete();
        if (m_code_cyc > cyc) m_code_cyc = -1;
        if (m_hi_start > cyc) begin m_hi_start = -1; m_hi_end = -1; end
        else if (m_hi_end > cyc) m_hi_end = cyc;
        if (m_err_cyc > cyc) m_err_cyc = -1;
        m_zero_cyc   = cyc + 1;
        m_clr_start  = cyc + 1;
        m_clr_end    = cyc + C;
        m_ready_from = cyc + C + 1;
      end else if (e_ready && s_valid) begin
        m_q.push_back(s_data);
        if (m_q.size() == BYTES) begin
          e_word = '0;
          e_xor  = '0;
          for (int i = 0; i < 16; i++) begin
            e_word = {e_word[119:0], m_q[i]};
            e_xor  = e_xor ^ m_q[i];
          end
          if (!CSUM || (m_q[BYTES-1] == e_xor)) begin
            m_pend_code  = e_word;
            m_code_cyc   = cyc + LAT;
            m_hi_start   = cyc + LAT + 1;
            m_hi_end     = cyc + LAT + S;
            m_ready_from = cyc + LAT + 2 * S + 1;
          end else begin
            m_err_cyc    = cyc + 2;
            m_ready_from = cyc + 2;
          end
          m_q.delete();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    int idle;
    if (gaps) begin
      idle = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      for (int i = 0; i < idle; i++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        step();
      end
    end
    budget = 0;
    s_data = b;
    while (!s_ready && budget < 100) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      budget++;
    end
    if (!s_ready) check("ready_timeout", 129'(s_ready), 129'd1);
    s_valid = 1'b1;
    s_data  = b;
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_code(input logic [127:0] w, input bit gaps, input bit bad, input int nbytes);
    logic [7:0] x;
    logic [7:0] b;
    x = '0;
    for (int i = 0; i < nbytes; i++) begin
      b = w[127 - 8 * i -: 8];
      x = x ^ b;
      send_byte(b, gaps);
    end
    if (CSUM && nbytes == 16) send_byte(bad ? (x ^ 8'h5A) : x, gaps);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (busy && budget < 100) begin step(); budget++; end
    if (busy) check("idle_timeout", 129'(busy), 129'd0);
  endtask

  task automatic wait_strobe();
    int budget;
    budget = 0;
    while (!code[128] && budget < 100) begin step(); budget++; end
    if (!code[128]) check("strobe_timeout", 129'(code[128]), 129'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] W037 = 128'h03000000_0000C123_00000000_00000099;

  initial begin
    int n;
    logic [7:0] hist;
    logic [127:0] w;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_code", code, 129'd0);
    check("rst_codes_reset", 129'(codes_reset), 129'd1);
    check("rst_s_ready", 129'(s_ready), 129'd0);
    check("rst_busy", 129'(busy), 129'd1);
    check("rst_applied", 129'(applied_count), 129'd0);
    check("rst_err", 129'(err_count), 129'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    model_init(cyc);
    chk_en = 1'b1;
    step();
    check("rel_s_ready", 129'(s_ready), 129'd1);
    check("rel_codes_reset", 129'(codes_reset), 129'd0);
    check("rel_busy", 129'(busy), 129'd0);

    // Directed code without gaps
    send_code(W037, 1'b0, 1'b0, 16);
    n = 0;
    hist = '0;
    for (int i = 0; i < 8; i++) begin
      hist[i] = code[128];
      if (!s_ready) n++;
      if (i == LAT - 1) begin
        check("r037_word", 129'(code[127:0]), 129'(W037));
        check("r037_load_strobe_low", 129'(code[128]), 129'd0);
      end
      step();
    end
    check("r037_strobe_pattern", 129'(hist), CSUM ? 129'h0C : 129'h06);
    check("r037_ready_low_cycles", 129'(n), 129'(4 + LAT));
    check("r037_applied", 129'(applied_count), 129'd1);

    // Clear after byte 9, then a fresh code
    send_code(128'hA1A2A3A4_A5A6A7A8_A9AAABAC_ADAEAFB0, 1'b0, 1'b0, 9);
    clear = 1'b1;
    #1;
    check("r038_strobe_on_clear", 129'(code[128]), 129'd0);
    step();
    clear = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (codes_reset) n++;
      step();
    end
    check("r038_codes_reset_cycles", 129'(n), 129'd2);
    w = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    send_code(w, 1'b0, 1'b0, 16);
    wait_idle();
    check("r038_fresh_word", 129'(code[127:0]), 129'(w));
    check("r038_applied", 129'(applied_count), 129'd1);

    // Clear held three cycles during a strobe
    send_code(128'h11223344_55667788_99AABBCC_DDEEFF00, 1'b1, 1'b0, 16);
    wait_strobe();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      clear = (i < 3);
      #1;
      if (i == 0) check("r042_strobe_forced_low", 129'(code[128]), 129'd0);
      if (codes_reset) n++;
      step();
    end
    clear = 1'b0;
    check("r042_codes_reset_cycles", 129'(n), 129'd4);
    wait_idle();
    check("r042_applied_zeroed", 129'(applied_count), 129'd0);

`ifdef CHEAT_LOADER_CHECKSUM_EN
    // Bad checksum rejected, then a good code with N+2 latency
    send_code(128'hDEADBEEF_00000000_CAFEF00D_12345678, 1'b0, 1'b1, 16);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (code[128]) n++;
      step();
    end
    check("r041_bad_no_strobe", 129'(n), 129'd0);
    check("r041_err_count", 129'(err_count), 129'd1);
    w = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    send_code(w, 1'b0, 1'b0, 16);
    check("r041_check_no_ready", 129'(s_ready), 129'd0);
    step();
    check("r041_load_word", 129'(code[127:0]), 129'(w));
    check("r041_load_strobe_low", 129'(code[128]), 129'd0);
    step();
    check("r041_strobe_high", 129'(code[128]), 129'd1);
    wait_idle();
`endif

    // Random codes with random s_valid toggling
    for (int c = 0; c < 300; c++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      send_code(w, 1'b1, CSUM && ($urandom_range(0, 9) == 0), 16);
    end
    wait_idle();
    check("r039_applied_saturated", 129'(applied_count), 129'd255);

    // Reset pulsed during STROBE_HI
    send_code(128'h55555555_AAAAAAAA_33333333_CCCCCCCC, 1'b0, 1'b0, 16);
    wait_strobe();
    chk_en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("r040_code_zero", code, 129'd0);
    check("r040_codes_reset", 129'(codes_reset), 129'd1);
    check("r040_s_ready", 129'(s_ready), 129'd0);
    check("r040_busy", 129'(busy), 129'd1);
    check("r040_applied", 129'(applied_count), 129'd0);
    step();
    check("r040_codes_reset_held", 129'(codes_reset), 129'd1);
    #2;
    reset_n = 1'b1;
    model_init(cyc);
    chk_en = 1'b1;
    step();
    check("r040_ready_after_release", 129'(s_ready), 129'd1);
    send_code(W037, 1'b1, 1'b0, 16);
    wait_idle();
    check("r040_applied_after", 129'(applied_count), 129'd1);

    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
